// File: rtl/aquisicao_veiculo.sv
// -----------------------------------------------------------------------------
// aquisicao_veiculo
//   Acquisition front-end feeding the combinational classifier `circuito`.
//   Synchronizes and debounces the axle / end-of-vehicle road sensors, counts
//   axles (saturating at 3), tracks the peak scale weight while the vehicle
//   passes and presents the {p3..p0, e1, e0} word under a valid/ack handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sensor_eixo  raw axle sensor (async), 1 = wheel present
//   sensor_fim   raw end-of-vehicle sensor (async), 1 = vehicle cleared
//   peso_in[3:0] scale reading, sampled every cycle while measuring
//   ack          consumer accepts the current word
//   p3..p0       latched peak weight (p3 = MSB)
//   e1, e0       latched axle code: 01 = 1, 10 = 2, 11 = 3 or more axles
//   valido       word valid
//   ocupado      measurement in progress
//   erro         one-cycle pulse, measurement aborted by timeout
//   perdido      one-cycle pulse, axle event seen while a word is pending
// -----------------------------------------------------------------------------
module aquisicao_veiculo #(
  parameter int unsigned DEB_CICLOS     = 4,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_eixo,
  input  logic       sensor_fim,
  input  logic [3:0] peso_in,
  input  logic       ack,
  output logic       p3,
  output logic       p2,
  output logic       p1,
  output logic       p0,
  output logic       e1,
  output logic       e0,
  output logic       valido,
  output logic       ocupado,
  output logic       erro,
  output logic       perdido
);

  localparam int unsigned DW = (DEB_CICLOS > 2) ? $clog2(DEB_CICLOS) : 1;
  localparam int unsigned TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

  typedef enum logic [1:0] {
    OCIOSO,
    MEDINDO,
    PRONTO
  } estado_t;

  // Index 0 = axle sensor, index 1 = end-of-vehicle sensor.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    ev;
  logic [DW-1:0] deb_cnt [2];

  logic          ev_eixo;
  logic          ev_fim;

  estado_t       estado;
  logic [1:0]    cont_eixo;
  logic [3:0]    peso_max;
  logic [TW-1:0] timer;
  logic [3:0]    peso_reg;
  logic [1:0]    eixo_reg;

  logic [1:0]    cont_nxt;
  logic [3:0]    peso_nxt;

  // Synchronizer + debouncer. A level change is accepted on the
  // DEB_CICLOS-th consecutive synchronized sample that differs from the
  // current debounced level; any sample equal to it restarts the count.
  // The event pulse is registered together with the accepted rising level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      ev         <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= {sensor_fim, sensor_eixo};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CICLOS - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
          ev[i]      <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev_eixo = ev[0];
  assign ev_fim  = ev[1];

  // Count-then-finalize: a same-cycle axle event is folded into the count
  // before the word is latched, and the current reading into the peak.
  always_comb begin
    cont_nxt = cont_eixo;
    if (ev_eixo && (cont_eixo != 2'd3)) begin
      cont_nxt = cont_eixo + 2'd1;
    end
    peso_nxt = (peso_in > peso_max) ? peso_in : peso_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      cont_eixo <= '0;
      peso_max  <= '0;
      timer     <= '0;
      peso_reg  <= '0;
      eixo_reg  <= '0;
      valido    <= 1'b0;
      ocupado   <= 1'b0;
      erro      <= 1'b0;
      perdido   <= 1'b0;
    end else begin
      erro    <= 1'b0;
      perdido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (ev_eixo) begin
            estado    <= MEDINDO;
            cont_eixo <= 2'd1;
            peso_max  <= peso_in;
            timer     <= '0;
            ocupado   <= 1'b1;
          end
        end
        MEDINDO: begin
          if (ev_fim) begin
            estado    <= PRONTO;
            cont_eixo <= cont_nxt;
            peso_max  <= peso_nxt;
            peso_reg  <= peso_nxt;
            eixo_reg  <= cont_nxt;
            valido    <= 1'b1;
            ocupado   <= 1'b0;
          end else if (ev_eixo) begin
            cont_eixo <= cont_nxt;
            peso_max  <= peso_nxt;
            timer     <= '0;
          end else if (timer == TW'(TIMEOUT_CICLOS - 1)) begin
            estado  <= OCIOSO;
            erro    <= 1'b1;
            ocupado <= 1'b0;
          end else begin
            peso_max <= peso_nxt;
            timer    <= timer + 1'b1;
          end
        end
        PRONTO: begin
          if (ev_eixo) begin
            perdido <= 1'b1;
          end
          if (ack) begin
            estado <= OCIOSO;
            valido <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          valido  <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign {p3, p2, p1, p0} = peso_reg;
  assign {e1, e0}         = eixo_reg;

endmodule

// File: tb/tb_aquisicao_veiculo.sv
// -----------------------------------------------------------------------------
// tb_aquisicao_veiculo
//   Drives sensor pulses and scale readings into aquisicao_veiculo and checks
//   the delivered {p, e} word against a vehicle-level model: peak = largest
//   reading applied during the passage, axle code = number of axles clipped
//   to 3. Pulse counters for erro/perdido/valido are kept by a monitor.
// -----------------------------------------------------------------------------
module tb_aquisicao_veiculo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_eixo = 1'b0;
  logic       sensor_fim = 1'b0;
  logic [3:0] peso_in = '0;
  logic       ack = 1'b0;
  logic       p3, p2, p1, p0, e1, e0;
  logic       valido, ocupado, erro, perdido;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int unsigned n_erro = 0;
  int unsigned n_perdido = 0;
  int unsigned n_valido = 0;
  int unsigned n_ocupado = 0;
  int unsigned n_any = 0;

  logic [3:0] wts [0:7];
  logic [5:0] palavra;

  always #5 clk = ~clk;

  aquisicao_veiculo #(
    .DEB_CICLOS    (4),
    .TIMEOUT_CICLOS(1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_eixo(sensor_eixo),
    .sensor_fim (sensor_fim),
    .peso_in    (peso_in),
    .ack        (ack),
    .p3         (p3),
    .p2         (p2),
    .p1         (p1),
    .p0         (p0),
    .e1         (e1),
    .e0         (e0),
    .valido     (valido),
    .ocupado    (ocupado),
    .erro       (erro),
    .perdido    (perdido)
  );

  assign palavra = {p3, p2, p1, p0, e1, e0};

  always @(negedge clk) begin
    if (erro)    n_erro++;
    if (perdido) n_perdido++;
    if (valido)  n_valido++;
    if (ocupado) n_ocupado++;
    if (palavra != 6'd0 || valido || ocupado || erro || perdido) n_any++;
  end

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the chosen sensors high for hi cycles then low for lo cycles.
  task automatic pulso(input bit eixo, input bit fim, input int unsigned hi, input int unsigned lo);
    sensor_eixo = eixo;
    sensor_fim  = fim;
    ciclos(hi);
    sensor_eixo = 1'b0;
    sensor_fim  = 1'b0;
    ciclos(lo);
  endtask

  // Expected word for a vehicle whose readings were wts[0..n_pulsos-1] and
  // whose axle total is n_eixos.
  function automatic logic [5:0] modelo(input int unsigned n_pulsos, input int unsigned n_eixos);
    int unsigned pico;
    int unsigned cod;
    pico = 0;
    for (int unsigned i = 0; i < n_pulsos; i++) begin
      if (int'(wts[i]) > pico) pico = int'(wts[i]);
    end
    cod = (n_eixos > 3) ? 3 : n_eixos;
    return {pico[3:0], cod[1:0]};
  endfunction

  task automatic espera_valido(input string tag);
    int unsigned k;
    k = 0;
    while (!valido && k < 200) begin
      ciclos(1);
      k++;
    end
    confere({tag, "_valido"}, {31'd0, valido}, 32'd1);
  endtask

  // n_sep separate axle pulses, then an end pulse (optionally with an axle
  // rising in the very same cycle). Reading wts[i] is held across pulse i.
  task automatic veiculo(input string tag, input int unsigned n_sep, input bit junto);
    logic [5:0] esperado;
    for (int unsigned i = 0; i < n_sep; i++) begin
      peso_in = wts[i];
      pulso(1'b1, 1'b0, 10, 10);
    end
    peso_in = wts[n_sep];
    pulso(junto, 1'b1, 10, 10);
    esperado = modelo(n_sep + 1, n_sep + (junto ? 1 : 0));
    espera_valido(tag);
    confere({tag, "_palavra"}, {26'd0, palavra}, {26'd0, esperado});
  endtask

  task automatic aceita(input string tag);
    logic [5:0] antes;
    antes = palavra;
    ack = 1'b1;
    ciclos(1);
    ack = 1'b0;
    confere({tag, "_ack_valido"}, {31'd0, valido}, 32'd0);
    confere({tag, "_ack_retem"}, {26'd0, palavra}, {26'd0, antes});
    ciclos(3);
  endtask

  initial begin
    int unsigned base_erro, base_perdido, base_valido, base_ocupado, base_any;
    logic [5:0] fixa;

    // 1. reset and glitch rejection
    rst_n = 1'b0;
    ciclos(3);
    confere("rst_palavra", {26'd0, palavra}, 32'd0);
    confere("rst_flags", {28'd0, valido, ocupado, erro, perdido}, 32'd0);
    rst_n = 1'b1;
    base_any = n_any;
    ciclos(50);
    confere("rst_quieto", n_any - base_any, 32'd0);
    base_ocupado = n_ocupado;
    pulso(1'b1, 1'b0, 2, 20);
    confere("glitch_ocupado", n_ocupado - base_ocupado, 32'd0);

    // 2. two-axle vehicle, readings 3 -> 9 -> 5
    wts[0] = 4'd3; wts[1] = 4'd9; wts[2] = 4'd5;
    veiculo("dois_eixos", 2, 1'b0);
    confere("dois_eixos_exato", {26'd0, palavra}, {26'd0, 6'b1001_10});
    fixa = palavra;
    for (int unsigned i = 0; i < 20; i++) begin
      peso_in = 4'($urandom_range(0, 15));
      ciclos(1);
      if (palavra != fixa || !valido) confere("estavel", {25'd0, valido, palavra}, {25'd0, 1'b1, fixa});
    end
    confere("estavel_fim", {25'd0, valido, palavra}, {25'd0, 1'b1, fixa});
    aceita("dois_eixos");

    // 3. saturation at three axles
    for (int unsigned i = 0; i < 6; i++) wts[i] = 4'd15;
    veiculo("satura", 5, 1'b0);
    confere("satura_exato", {26'd0, palavra}, {26'd0, 6'b1111_11});
    aceita("satura");

    // 4. timeout
    base_erro = n_erro;
    base_valido = n_valido;
    peso_in = 4'd7;
    pulso(1'b1, 1'b0, 10, 10);
    confere("timeout_ocupado", {31'd0, ocupado}, 32'd1);
    ciclos(1100);
    confere("timeout_erro", n_erro - base_erro, 32'd1);
    confere("timeout_valido", n_valido - base_valido, 32'd0);
    confere("timeout_livre", {31'd0, ocupado}, 32'd0);
    pulso(1'b0, 1'b1, 10, 20);
    confere("fim_ignorado", {30'd0, valido, ocupado}, 32'd0);

    // 5. overrun while a word is pending, then same-cycle axle + end
    wts[0] = 4'($urandom_range(0, 15)); wts[1] = 4'($urandom_range(0, 15));
    veiculo("perdido_v", 1, 1'b0);
    fixa = palavra;
    base_perdido = n_perdido;
    pulso(1'b1, 1'b0, 10, 10);
    confere("perdido_pulso", n_perdido - base_perdido, 32'd1);
    confere("perdido_palavra", {25'd0, valido, palavra}, {25'd0, 1'b1, fixa});
    aceita("perdido_v");
    wts[0] = 4'($urandom_range(0, 15)); wts[1] = 4'($urandom_range(0, 15));
    veiculo("junto", 1, 1'b1);
    confere("junto_eixos", {30'd0, palavra[1:0]}, 32'd2);
    aceita("junto");

    // 6. asynchronous reset mid-measurement
    base_erro = n_erro;
    peso_in = 4'd4;
    pulso(1'b1, 1'b0, 10, 10);
    pulso(1'b1, 1'b0, 10, 5);
    confere("pre_reset_ocupado", {31'd0, ocupado}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    confere("reset_assinc", {29'd0, ocupado, valido, erro}, 32'd0);
    ciclos(3);
    rst_n = 1'b1;
    ciclos(1200);
    confere("reset_sem_erro", n_erro - base_erro, 32'd0);
    wts[0] = 4'($urandom_range(0, 15)); wts[1] = 4'($urandom_range(0, 15));
    veiculo("pos_reset", 1, 1'b0);
    confere("pos_reset_eixos", {30'd0, palavra[1:0]}, 32'd1);
    aceita("pos_reset");

    // random vehicles
    for (int unsigned v = 0; v < 10; v++) begin
      int unsigned n;
      bit j;
      n = $urandom_range(1, 5);
      j = 1'($urandom_range(0, 1));
      for (int unsigned i = 0; i <= n; i++) wts[i] = 4'($urandom_range(0, 15));
      veiculo("aleatorio", n, j);
      aceita("aleatorio");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
